// File: rtl/gate_truth_checker_pkg.sv
// Shared types and constants for the two-input gate exerciser/checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int IDX_C = 0;
  localparam int IDX_D = 1;
  localparam int IDX_E = 2;
  localparam int IDX_F = 3;
  localparam int IDX_G = 4;
  localparam int IDX_H = 5;
  localparam int IDX_I = 6;

  localparam int ORDER_NAND_FIRST = 0;
  localparam int ORDER_XOR_FIRST  = 1;

endpackage

// File: rtl/gate_truth_checker_golden.sv
// Combinational reference for the seven gate outputs, packed {i,h,g,f,e,d,c}.
module gate_golden_model
  import gate_chk_pkg::*;
#(
  parameter int PIN_ORDER = ORDER_NAND_FIRST
) (
  input  logic       a,
  input  logic       b,
  output logic [6:0] expected
);

  always_comb begin
    expected        = '0;
    expected[IDX_C] = ~a;
    expected[IDX_D] = a & b;
    expected[IDX_E] = a | b;
    expected[IDX_I] = ~(a ^ b);
    // Only f/g/h move between the two pinouts.
    if (PIN_ORDER == ORDER_XOR_FIRST) begin
      expected[IDX_F] = a ^ b;
      expected[IDX_G] = ~(a & b);
      expected[IDX_H] = ~(a | b);
    end else begin
      expected[IDX_F] = ~(a & b);
      expected[IDX_G] = ~(a | b);
      expected[IDX_H] = a ^ b;
    end
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps a/b through 00,01,10,11, samples the gate outputs and accumulates a mismatch mask.
// Optional first-failure log enabled by defining GATE_CHK_FAIL_LOG_EN.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PIN_ORDER     = ORDER_NAND_FIRST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [6:0] dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_mask
`ifdef GATE_CHK_FAIL_LOG_EN
  ,
  output logic       fail_valid,
  output logic [1:0] fail_vec
`endif
);

  localparam int CNT_W = ($clog2(SETTLE_CYCLES + 1) < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       err_mask_q, err_mask_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [6:0]       expected;
  logic [6:0]       mismatch;
`ifdef GATE_CHK_FAIL_LOG_EN
  logic             fail_valid_q, fail_valid_d;
  logic [1:0]       fail_vec_q, fail_vec_d;
`endif

  gate_golden_model #(
    .PIN_ORDER (PIN_ORDER)
  ) u_golden (
    .a        (vec_q[1]),
    .b        (vec_q[0]),
    .expected (expected)
  );

  assign mismatch = dut_out ^ expected;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    err_mask_d = err_mask_q;
`ifdef GATE_CHK_FAIL_LOG_EN
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = SETTLE;
          vec_d      = 2'd0;
          cnt_d      = '0;
          err_mask_d = '0;
`ifdef GATE_CHK_FAIL_LOG_EN
          fail_valid_d = 1'b0;
          fail_vec_d   = 2'd0;
`endif
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = CHECK;
      end
      CHECK: begin
        err_mask_d = err_mask_q | mismatch;
`ifdef GATE_CHK_FAIL_LOG_EN
        if (!fail_valid_q && (|mismatch)) begin
          fail_valid_d = 1'b1;
          fail_vec_d   = vec_q;
        end
`endif
        if (vec_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = SETTLE;
          vec_d   = vec_q + 2'd1;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered alongside the state they describe.
    busy_d = (state_d == SETTLE) || (state_d == CHECK);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && ~(|err_mask_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= 2'd0;
      cnt_q      <= '0;
      err_mask_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
`ifdef GATE_CHK_FAIL_LOG_EN
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      err_mask_q <= err_mask_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
`ifdef GATE_CHK_FAIL_LOG_EN
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
`endif
    end
  end

  assign a        = vec_q[1];
  assign b        = vec_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_mask = err_mask_q;
`ifdef GATE_CHK_FAIL_LOG_EN
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
`endif

endmodule
